framebuffer_writer: RTL
=======================

Name: framebuffer_writer

Overview:
- Write-side counterpart of the framebuffer scan-out path. Accepts the ray marcher's grayscale pixel stream in raster order and drives write address, data and enable into the framebuffer BRAM write port.
- Manages double buffering. Scan-out always reads one buffer while this block fills the other.
- Buffers swap only at a vsync rising edge after a complete frame has been written, so the display never shows a partial frame.

Parameters:
- WIDTH, 320, framebuffer width in pixels (matches DISPLAY_WIDTH).
- HEIGHT, 240, framebuffer height in pixels.
- PIX_BITS, 4, grayscale pixel width.
- ADDR_BITS, 18, BRAM address width; must satisfy 2^ADDR_BITS >= 2*WIDTH*HEIGHT.

Ports:
- clk_in  input  1  system clock; also the clock of the video timing generator.
- rst_in  input  1  synchronous, active-high reset.
- pixel_valid_in  input  1  ray marcher presents a pixel.
- pixel_data_in  input  PIX_BITS  grayscale value.
- pixel_ready_out  output  1  block accepts a pixel this cycle.
- pixel_x_out  output  clog2(WIDTH)  x coordinate the next accepted pixel occupies.
- pixel_y_out  output  clog2(HEIGHT)  y coordinate the next accepted pixel occupies.
- vsync_in  input  1  active-high vsync from the video timing generator, before pin inversion.
- write_en_out  output  1  BRAM write enable.
- write_addr_out  output  ADDR_BITS  BRAM write address.
- write_data_out  output  PIX_BITS  BRAM write data.
- display_buf_out  output  1  buffer scan-out must read; the read address offset is display_buf_out*WIDTH*HEIGHT.
- frame_done_out  output  1  one-cycle pulse when the last pixel of a frame is accepted.
- swap_out  output  1  one-cycle pulse on the cycle display_buf_out toggles.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Port names are clk_in and rst_in.
- Reset values:
  - state = WRITE; x = 0, y = 0.
  - display_buf_out = 0; write buffer = 1.
  - write_en_out = 0, write_addr_out = 0, write_data_out = 0.
  - frame_done_out = 0, swap_out = 0.
  - pixel_ready_out = 0 while rst_in is high.
- Write buffer is always ~display_buf_out.
- Buffer base address: 0 for buffer 0, WIDTH*HEIGHT for buffer 1.
- Address generation: maintained as an incrementing counter (base + y*WIDTH + x). No multiplier.
- pixel_ready_out is combinational: 1 exactly when state == WRITE and rst_in == 0.
- Accept = pixel_valid_in && pixel_ready_out.
- Accept latency: 1 cycle. On the cycle after an accept:
  - write_en_out = 1.
  - write_addr_out = address of (x,y) at accept time.
  - write_data_out = the accepted pixel.
- With no accept, write_en_out = 0 on the next cycle. write_addr_out and write_data_out hold their previous values.
- Back-to-back accepts give one write per cycle with no bubbles.
- Coordinate advance on accept:
  - x increments.
  - If x == WIDTH-1, then x <- 0 and y increments.
  - If additionally y == HEIGHT-1, the accept is the last pixel: y <- 0, the address counter reloads the base of the other buffer, frame_done_out pulses on the next cycle, and state -> WAIT_SWAP.
- State WAIT_SWAP:
  - pixel_ready_out = 0; the upstream stalls.
  - Rising-edge detection: vsync_in == 1 && vsync_q == 0, where vsync_q is vsync_in registered. vsync_q resets to 1 so that a vsync level already high at reset does not count as an edge.
  - On a detected edge: display_buf_out toggles, swap_out pulses that cycle (registered, visible one cycle later alongside the new display_buf_out), and state -> WRITE. The address counter already points at the base of the new write buffer.
- Edges are evaluated only in WAIT_SWAP. An edge coinciding with the last-pixel accept cycle is ignored; the block waits for the next vsync.
- An accept with pixel_valid_in low or in WAIT_SWAP performs no write and no coordinate change.
- Reset mid-frame or in WAIT_SWAP discards partial progress and returns everything to reset values, including display_buf_out = 0.
- pixel_data_in is ignored when no accept occurs.

Test Plan:
- WIDTH=4, HEIGHT=2, valid held high from reset release -> 8 consecutive writes with addresses 8..15, data echoed 1 cycle later; frame_done_out pulses once with the 8th write; pixel_ready_out drops to 0 after the 8th accept.
- Continue: vsync_in held 0 for 20 cycles, then driven 1 -> no writes while waiting; swap_out pulses once, display_buf_out = 1; next frame writes addresses 0..7.
- Valid toggled 1,0,1,0 -> writes only on accepted cycles; pixel_x_out/pixel_y_out go 0,0 -> 1,0 -> 2,0 without skipping; no gaps in addresses.
- vsync_in rising on the same cycle as the last accept, then low for 10 cycles, then high -> no swap on the first edge; swap on the second edge.
- rst_in asserted for 1 cycle after 3 pixels of the 2nd frame -> display_buf_out = 0, write_en_out = 0; next accept writes address 8 (buffer 1, x=0, y=0).
- vsync_in high through reset release, never falling -> no spurious swap after the first frame completes.

Source files
------------

// File: rtl/framebuffer_writer_if.sv
// Pixel stream from the ray marcher plus the framebuffer BRAM write port.
// The slave side is the framebuffer writer itself; the master side is the
// surrounding system (ray marcher drives valid/data, BRAM consumes writes).
interface framebuffer_writer_if #(
    parameter int PIX_BITS  = 4,
    parameter int ADDR_BITS = 18,
    parameter int X_BITS    = 9,
    parameter int Y_BITS    = 8
);
    logic                 pixel_valid_in;
    logic [PIX_BITS-1:0]  pixel_data_in;
    logic                 pixel_ready_out;
    logic [X_BITS-1:0]    pixel_x_out;
    logic [Y_BITS-1:0]    pixel_y_out;
    logic                 write_en_out;
    logic [ADDR_BITS-1:0] write_addr_out;
    logic [PIX_BITS-1:0]  write_data_out;

    modport master (
        output pixel_valid_in,
        output pixel_data_in,
        input  pixel_ready_out,
        input  pixel_x_out,
        input  pixel_y_out,
        input  write_en_out,
        input  write_addr_out,
        input  write_data_out
    );

    modport slave (
        input  pixel_valid_in,
        input  pixel_data_in,
        output pixel_ready_out,
        output pixel_x_out,
        output pixel_y_out,
        output write_en_out,
        output write_addr_out,
        output write_data_out
    );
endinterface

// File: rtl/framebuffer_writer.sv
// Framebuffer writer: takes the raster-ordered grayscale pixel stream, writes
// it into the back buffer of a double-buffered framebuffer, and swaps buffers
// on the first vsync rising edge after a full frame has been written.
module framebuffer_writer #(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int PIX_BITS  = 4,
    parameter int ADDR_BITS = 18
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    framebuffer_writer_if.slave  fb,
    input  logic                 vsync_in,
    output logic                 display_buf_out,
    output logic                 frame_done_out,
    output logic                 swap_out
);
    localparam int X_BITS = $clog2(WIDTH);
    localparam int Y_BITS = $clog2(HEIGHT);

    localparam logic [X_BITS-1:0]    X_MAX      = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0]    Y_MAX      = Y_BITS'(HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] FRAME_SIZE = ADDR_BITS'(WIDTH * HEIGHT);

    typedef enum logic {
        S_WRITE     = 1'b0,
        S_WAIT_SWAP = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [X_BITS-1:0]    x_q;
    logic [Y_BITS-1:0]    y_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 display_buf_q;
    logic                 vsync_q;
    logic                 write_en_q;
    logic [ADDR_BITS-1:0] write_addr_q;
    logic [PIX_BITS-1:0]  write_data_q;
    logic                 frame_done_q;
    logic                 swap_q;

    logic pixel_ready;
    logic accept;
    logic last_pixel;
    logic vsync_rise;
    logic swap_now;

    // Handshake, end-of-frame and swap qualification.
    assign pixel_ready = (state_q == S_WRITE) && !rst_in;
    assign accept      = fb.pixel_valid_in && pixel_ready;
    assign last_pixel  = accept && (x_q == X_MAX) && (y_q == Y_MAX);
    assign vsync_rise  = vsync_in && !vsync_q;
    assign swap_now    = (state_q == S_WAIT_SWAP) && vsync_rise;

    // State register.
    always_ff @(posedge clk_in) begin
        // NOTE: every sequential block uses non-blocking assignments so all
        // registers update from pre-edge values regardless of statement order.
        if (rst_in) begin
            state_q <= S_WRITE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill the back buffer, then hold off until a vsync edge.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            S_WRITE:     if (last_pixel) state_d = S_WAIT_SWAP;
            S_WAIT_SWAP: if (vsync_rise) state_d = S_WRITE;
            default:     state_d = S_WRITE;
        endcase
    end

    // Raster coordinates and the incrementing write address counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= FRAME_SIZE;  // buffer 1 is the first back buffer
        end else if (accept) begin
            if (x_q == X_MAX) begin
                x_q <= '0;
                if (y_q == Y_MAX) begin
                    y_q    <= '0;
                    // The next back buffer is the one currently displayed.
                    addr_q <= display_buf_q ? FRAME_SIZE : '0;
                end else begin
                    y_q    <= y_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
            end else begin
                x_q    <= x_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    // BRAM write port: one write the cycle after each accept; addr/data hold otherwise.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            write_en_q <= accept;
            if (accept) begin
                write_addr_q <= addr_q;
                write_data_q <= fb.pixel_data_in;
            end
        end
    end

    // Buffer selection, vsync edge history and the status pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            display_buf_q <= 1'b0;
            vsync_q       <= 1'b1;  // a vsync already high at reset is not an edge
            frame_done_q  <= 1'b0;
            swap_q        <= 1'b0;
        end else begin
            vsync_q      <= vsync_in;
            frame_done_q <= last_pixel;
            swap_q       <= swap_now;
            if (swap_now) begin
                display_buf_q <= ~display_buf_q;
            end
        end
    end

    assign fb.pixel_ready_out = pixel_ready;
    assign fb.pixel_x_out     = x_q;
    assign fb.pixel_y_out     = y_q;
    assign fb.write_en_out    = write_en_q;
    assign fb.write_addr_out  = write_addr_q;
    assign fb.write_data_out  = write_data_q;
    assign display_buf_out    = display_buf_q;
    assign frame_done_out     = frame_done_q;
    assign swap_out           = swap_q;
endmodule
